// File: rtl/quad_pkg.sv
// quad_pkg: shared types and constants for the quadrature decoder.
//   quad_state_e  - decoder FSM states (S_INIT plus one state per {A,B} pair)
//   DEB_CYCLES_DEF - default debounce length in clk cycles
//   DEB_CNT_W      - width of the debounce stability counter (covers 1..15)
//   ERR_CNT_W / ERR_CNT_MAX - illegal-transition counter width and saturation
//                    value (counter only exists when QUAD_ERR_CNT_EN is defined)
package quad_pkg;

  typedef enum logic [2:0] {
    S_INIT = 3'd0,
    S00    = 3'd1,
    S01    = 3'd2,
    S11    = 3'd3,
    S10    = 3'd4
  } quad_state_e;

  localparam int unsigned DEB_CYCLES_DEF = 4;
  localparam int unsigned DEB_CNT_W      = 4;

  localparam int unsigned         ERR_CNT_W   = 8;
  localparam logic [ERR_CNT_W-1:0] ERR_CNT_MAX = 8'd255;

  // Map a debounced {A,B} pair onto its FSM state.
  function automatic quad_state_e pair_to_state(input logic [1:0] pair);
    case (pair)
      2'b00:   return S00;
      2'b01:   return S01;
      2'b11:   return S11;
      default: return S10;
    endcase
  endfunction

  // Pair represented by a state; S_INIT has no pair and reads as 00.
  function automatic logic [1:0] state_to_pair(input quad_state_e st);
    case (st)
      S01:     return 2'b01;
      S11:     return 2'b11;
      S10:     return 2'b10;
      default: return 2'b00;
    endcase
  endfunction

  // Position along the forward cycle 00->01->11->10 (Gray to binary).
  function automatic logic [1:0] pair_to_pos(input logic [1:0] pair);
    return {pair[1], pair[1] ^ pair[0]};
  endfunction

endpackage

// File: rtl/quad_debounce.sv
// quad_debounce: 2-flop synchronizer followed by a stability-count debouncer
// for one encoder channel.
//   clk, rst  - clock, synchronous active-high reset
//   raw_in    - asynchronous channel input
//   level     - debounced level (meaningful once qual is high)
//   qual      - set once the first level has been stable for DEB_CYCLES
// After qualification, level follows the synchronized input only once it has
// differed from level for DEB_CYCLES consecutive cycles; a reverting
// candidate clears the count.
module quad_debounce
  import quad_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic raw_in,
  output logic level,
  output logic qual
);

  localparam logic [DEB_CNT_W-1:0] DEB_CNT = DEB_CYCLES[DEB_CNT_W-1:0];

  logic                 sync1_q, sync1_d;
  logic                 sync2_q, sync2_d;
  logic                 level_q, level_d;
  logic                 qual_q, qual_d;
  logic [DEB_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    level_d = level_q;
    qual_d  = qual_q;
    cnt_d   = cnt_q;

    if (!qual_q) begin
      // Before qualification level_q tracks the current candidate; any change
      // restarts the count.
      if (sync2_q != level_q) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else if (cnt_q == DEB_CNT) begin
        qual_d = 1'b1;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (sync2_q != level_q) begin
      if (cnt_q == DEB_CNT) begin
        level_d = sync2_q;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      qual_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      qual_q  <= qual_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign qual  = qual_q;

endmodule

// File: rtl/quad_decoder.sv
// quad_decoder: quadrature encoder decoder producing step/dir for a
// downstream position counter.
//   clk, rst  - clock, synchronous active-high reset
//   a_in,b_in - asynchronous encoder channels
//   step      - one-cycle pulse per valid transition
//   dir       - 1 forward / 0 reverse, held between steps
//   err       - one-cycle pulse when both channels change together
//   err_cnt   - saturating err pulse count; port exists only when the
//               QUAD_ERR_CNT_EN macro is defined
//
// state  | meaning
// S_INIT | waiting for both channels to qualify; first pair loads silently
// S00    | last accepted {A,B} = 00
// S01    | last accepted {A,B} = 01
// S11    | last accepted {A,B} = 11
// S10    | last accepted {A,B} = 10
module quad_decoder
  import quad_pkg::*;
#(
  parameter int unsigned DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic a_in,
  input  logic b_in,
  output logic step,
  output logic dir,
  output logic err
`ifdef QUAD_ERR_CNT_EN
  ,
  output logic [ERR_CNT_W-1:0] err_cnt
`endif
);

  logic a_deb, a_qual;
  logic b_deb, b_qual;

  quad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_a (
    .clk   (clk),
    .rst   (rst),
    .raw_in(a_in),
    .level (a_deb),
    .qual  (a_qual)
  );

  quad_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_b (
    .clk   (clk),
    .rst   (rst),
    .raw_in(b_in),
    .level (b_deb),
    .qual  (b_qual)
  );

  quad_state_e state_q, state_d;
  logic        step_q, step_d;
  logic        dir_q, dir_d;
  logic        err_q, err_d;
  logic [1:0]  new_pair;
  logic [1:0]  delta;

  assign new_pair = {a_deb, b_deb};
  // Forward distance along the Gray cycle: 1 = forward, 3 = reverse,
  // 2 = both bits flipped (illegal), 0 = no change.
  assign delta    = pair_to_pos(new_pair) - pair_to_pos(state_to_pair(state_q));

  always_comb begin
    state_d = state_q;
    step_d  = 1'b0;
    dir_d   = dir_q;
    err_d   = 1'b0;

    if (state_q == S_INIT) begin
      if (a_qual && b_qual) begin
        state_d = pair_to_state(new_pair);
      end
    end else begin
      state_d = pair_to_state(new_pair);
      case (delta)
        2'd1: begin
          step_d = 1'b1;
          dir_d  = 1'b1;
        end
        2'd3: begin
          step_d = 1'b1;
          dir_d  = 1'b0;
        end
        2'd2: err_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      step_q  <= 1'b0;
      dir_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      dir_q   <= dir_d;
      err_q   <= err_d;
    end
  end

  assign step = step_q;
  assign dir  = dir_q;
  assign err  = err_q;

`ifdef QUAD_ERR_CNT_EN
  logic [ERR_CNT_W-1:0] err_cnt_q, err_cnt_d;

  // Counts in the same edge that raises err so the two stay aligned.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_d && (err_cnt_q != ERR_CNT_MAX)) begin
      err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule
